// File: rtl/xscoreboard.sv
// xscoreboard: register-mapped packed-BCD scoreboard for N_PLAYERS channels,
// driving a multiplexed active-low 7-segment display with winner blink.
module xscoreboard #(
   parameter int unsigned         N_PLAYERS    = 2,
   parameter int unsigned         DIGITS       = 2,
   parameter int unsigned         SCAN_DIV     = 50000,
   parameter logic [4*DIGITS-1:0] WIN_BCD      = 8'h10,
   parameter int unsigned         BLINK_FRAMES = 32,
   parameter int unsigned         ADDR_W       = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sel,
   input  logic                        we,
   input  logic [ADDR_W-1:0]           addr,
   input  logic [7:0]                  data_in,
   output logic [7:0]                  data_out,
   output logic [7:0]                  cathode,
   output logic [N_PLAYERS*DIGITS-1:0] anode,
   output logic [N_PLAYERS-1:0]        win,
   output logic                        game_over
);
   localparam int unsigned ND = N_PLAYERS * DIGITS;
   localparam int unsigned SW = 4 * DIGITS;
   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (ND > 1) ? $clog2(ND) : 1;
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [ADDR_W-1:0] CTRL_ADDR = '1;
   localparam logic [PW-1:0]     PRE_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST  = IW'(ND - 1);
   localparam logic [FW-1:0]     FRM_LAST  = FW'(BLINK_FRAMES - 1);

   typedef enum logic {PH_ON, PH_OFF} phase_t;

   // Saturating packed-BCD increment with ripple carry across all digits.
   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          carry;
      logic          all9;
      r     = v;
      carry = 1'b1;
      all9  = 1'b1;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (v[4*d +: 4] != 4'd9) all9 = 1'b0;
         if (carry) begin
            if (v[4*d +: 4] == 4'd9) begin
               r[4*d +: 4] = 4'd0;
            end else begin
               r[4*d +: 4] = v[4*d +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return all9 ? v : r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   logic [N_PLAYERS-1:0][SW-1:0] score;
   logic [N_PLAYERS-1:0][SW-1:0] score_nxt;
   logic [N_PLAYERS-1:0]         win_nxt;
   logic [N_PLAYERS-1:0]         wr_player;
   logic                         wr_ctrl;
   logic                         clr_all;
   logic                         blank;
   logic [7:0]                   rd_data;
   logic [PW-1:0]                presc;
   logic [IW-1:0]                idx;
   logic                         step;
   logic                         frame_end;
   logic [7:0]                   cath_nxt;
   logic [ND-1:0]                anode_nxt;
   logic [FW-1:0]                frm_cnt;
   logic [FW-1:0]                frm_cnt_nxt;
   phase_t                       phase;
   phase_t                       phase_nxt;

   assign game_over = |win;

   always_comb begin
      wr_ctrl   = sel && we && (addr == CTRL_ADDR);
      clr_all   = wr_ctrl && data_in[0];
      wr_player = '0;
      for (int unsigned p = 0; p < N_PLAYERS; p++)
         if (sel && we && (addr == ADDR_W'(p)) && (addr != CTRL_ADDR)) wr_player[p] = 1'b1;
   end

   always_comb begin
      score_nxt = score;
      win_nxt   = win;
      if (clr_all) begin
         score_nxt = '0;
         win_nxt   = '0;
      end
      for (int unsigned p = 0; p < N_PLAYERS; p++) begin
         if (wr_player[p]) begin
            if (data_in[1]) begin
               score_nxt[p] = '0;
               win_nxt[p]   = 1'b0;
            end else if (data_in[0] && !game_over) begin
               score_nxt[p] = bcd_inc(score[p]);
               if (score_nxt[p] == WIN_BCD) win_nxt[p] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (addr == CTRL_ADDR) begin
         rd_data = {5'b0, blank, game_over, |win};
      end else begin
         for (int unsigned p = 0; p < N_PLAYERS; p++)
            if (addr == ADDR_W'(p)) rd_data = 8'(score[p]);
      end
   end

   // Display word for the digit being stepped onto; leading zeros blank the
   // segments but the anode still fires so the scan duty stays uniform.
   always_comb begin
      logic lead;
      lead      = 1'b0;
      step      = (presc == PRE_LAST);
      frame_end = step && (idx == IDX_LAST);
      cath_nxt  = 8'hFF;
      anode_nxt = '1;
      for (int unsigned p = 0; p < N_PLAYERS; p++) begin
         for (int unsigned d = 0; d < DIGITS; d++) begin
            if (idx == IW'(p*DIGITS + d)) begin
               lead = 1'b1;
               for (int unsigned k = d; k < DIGITS; k++)
                  if (score[p][4*k +: 4] != 4'd0) lead = 1'b0;
               cath_nxt[6:0] = (d != 0 && lead) ? 7'h7F : seg7(score[p][4*d +: 4]);
               cath_nxt[7]   = !(p >= 1 && d == 0);
               if (!blank && !(phase == PH_OFF && win[p])) anode_nxt[p*DIGITS + d] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      phase_nxt   = phase;
      frm_cnt_nxt = frm_cnt;
      if (clr_all || !game_over) begin
         phase_nxt   = PH_ON;
         frm_cnt_nxt = '0;
      end else if (frame_end) begin
         if (frm_cnt == FRM_LAST) begin
            frm_cnt_nxt = '0;
            phase_nxt   = (phase == PH_ON) ? PH_OFF : PH_ON;
         end else begin
            frm_cnt_nxt = frm_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase   <= PH_ON;
         frm_cnt <= '0;
      end else begin
         phase   <= phase_nxt;
         frm_cnt <= frm_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         score    <= '0;
         win      <= '0;
         blank    <= 1'b0;
         data_out <= '0;
         presc    <= '0;
         idx      <= '0;
         anode    <= '1;
         cathode  <= '1;
      end else begin
         score <= score_nxt;
         win   <= win_nxt;
         if (wr_ctrl) blank <= data_in[1];
         if (sel && !we) data_out <= rd_data;
         presc <= step ? '0 : presc + 1'b1;
         if (step) begin
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            anode   <= anode_nxt;
            cathode <= cath_nxt;
         end
      end
   end
endmodule

// File: tb/tb_xscoreboard.sv
// Scoreboard bench for xscoreboard: reads queue their expected byte and a
// monitor compares data_out one cycle later; display checks use a scan model.
`timescale 1ns/1ps
module tb_xscoreboard;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sel = 1'b0;
   logic       sel_s = 1'b0;
   logic       we = 1'b0;
   logic [3:0] addr = '0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out, cathode, data_out_s, cathode_s;
   logic [3:0] anode, anode_s;
   logic [1:0] win, win_s;
   logic       game_over, game_over_s;

   int errors = 0;
   int checks = 0;
   int unsigned sc = 0;

   typedef struct { string name; logic [7:0] val; } exp_t;
   exp_t rdq[$];

   always #5 clk = ~clk;

   xscoreboard #(.N_PLAYERS(2), .DIGITS(2), .SCAN_DIV(4), .WIN_BCD(8'h10),
                 .BLINK_FRAMES(2), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
      .data_out(data_out), .cathode(cathode), .anode(anode), .win(win),
      .game_over(game_over));

   xscoreboard #(.N_PLAYERS(2), .DIGITS(2), .SCAN_DIV(4), .WIN_BCD(8'h99),
                 .BLINK_FRAMES(2), .ADDR_W(4)) dut_sat (
      .clk(clk), .rst(rst), .sel(sel_s), .we(we), .addr(addr), .data_in(data_in),
      .data_out(data_out_s), .cathode(cathode_s), .anode(anode_s), .win(win_s),
      .game_over(game_over_s));

   // clocks since reset release; a scan step lands on every 4th one
   always @(posedge clk) begin
      if (!rst) sc <= 0;
      else      sc <= sc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for scan step", name);
   endtask

   initial begin : monitor
      exp_t e;
      logic use_s;
      forever begin
         @(posedge clk);
         if (rst && (sel || sel_s) && !we) begin
            use_s = sel_s;
            @(negedge clk);
            if (rdq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL read_unexpected: got read with empty queue");
            end else begin
               e = rdq.pop_front();
               check(e.name, use_s ? data_out_s : data_out, e.val);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic wr(input bit s, input logic [3:0] a, input logic [7:0] d);
      sel = !s; sel_s = s; we = 1'b1; addr = a; data_in = d;
      @(negedge clk);
      sel = 1'b0; sel_s = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input bit s, input logic [3:0] a, input logic [7:0] exp, input string name);
      rdq.push_back('{name, exp});
      sel = !s; sel_s = s; we = 1'b0; addr = a;
      @(negedge clk);
      sel = 1'b0; sel_s = 1'b0;
   endtask

   task automatic wait_step(output int unsigned d, output bit ok);
      ok = 1'b0;
      d  = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (sc >= 4 && sc % 4 == 0) begin
            ok = 1'b1;
            d  = (sc / 4 - 1) % 4;
         end
      end
   endtask

   task automatic wait_digit(input int unsigned d, output bit ok);
      int unsigned cur;
      bit          got;
      ok = 1'b0;
      for (int i = 0; i < 6 && !ok; i++) begin
         wait_step(cur, got);
         if (got && cur == d) ok = 1'b1;
      end
   endtask

   task automatic check_digit(input int unsigned d, input logic [3:0] exp_an,
                              input logic [7:0] exp_cat, input string name);
      bit ok;
      wait_digit(d, ok);
      if (!ok) timeout(name);
      else begin
         check({name, "_anode"}, anode, exp_an);
         check({name, "_cathode"}, cathode, exp_cat);
      end
   endtask

   initial begin : stim
      bit          ok;
      int unsigned d;
      int          off1, on1, ok0, fr;
      bit          pat_ok, step_lost;
      logic        bl [8];

      // reset held, then released
      repeat (3) @(negedge clk);
      check("rst_anode", anode, 4'b1111);
      check("rst_cathode", cathode, 8'hFF);
      check("rst_data_out", data_out, 8'h00);
      check("rst_win", {game_over, win}, 3'b000);
      check("rst_sat_anode", anode_s, 4'b1111);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rel_anode_3clk", anode, 4'b1111);
      @(negedge clk);
      check("rel_anode_4clk", anode, 4'b1110);
      check("rel_cathode_4clk", cathode, 8'hC0);

      // saturation instance: run player 0 up to and beyond 99
      repeat (49) wr(1'b1, 4'd0, 8'h01);
      rd(1'b1, 4'd0, 8'h49, "sat_49");
      repeat (50) wr(1'b1, 4'd0, 8'h01);
      rd(1'b1, 4'd0, 8'h99, "sat_99");
      check("sat_win", {game_over_s, win_s}, 3'b101);
      wr(1'b1, 4'd0, 8'h01);
      rd(1'b1, 4'd0, 8'h99, "sat_hold_99");

      // carry into tens digit
      repeat (9) wr(1'b0, 4'd0, 8'h01);
      rd(1'b0, 4'd0, 8'h09, "p0_09");
      check("p0_09_win", win, 2'b00);
      wr(1'b0, 4'd0, 8'h01);
      rd(1'b0, 4'd0, 8'h10, "p0_carry_10");
      check("p0_win", {game_over, win}, 3'b101);
      rd(1'b0, 4'd15, 8'h03, "ctrl_after_p0_win");

      wr(1'b0, 4'd15, 8'h01);
      rd(1'b0, 4'd0, 8'h00, "clrall_p0");
      rd(1'b0, 4'd15, 8'h00, "clrall_ctrl");
      check("clrall_win", {game_over, win}, 3'b000);

      // player 1 win and game_over lockout
      repeat (9) wr(1'b0, 4'd1, 8'h01);
      rd(1'b0, 4'd1, 8'h09, "p1_09");
      check("p1_09_win", win, 2'b00);
      wr(1'b0, 4'd1, 8'h01);
      check("p1_win_edge", {game_over, win}, 3'b110);
      wr(1'b0, 4'd0, 8'h01);
      rd(1'b0, 4'd0, 8'h00, "p0_locked");
      rd(1'b0, 4'd1, 8'h10, "p1_10");
      rd(1'b0, 4'd15, 8'h03, "ctrl_over");

      // winner blink over 8 whole frames
      repeat (20) @(negedge clk);
      off1 = 0; on1 = 0; ok0 = 0; fr = 0; pat_ok = 1'b1; step_lost = 1'b0;
      for (int f = 0; f < 8; f++) bl[f] = 1'b0;
      wait_digit(0, ok);
      if (!ok) timeout("blink_sync");
      for (int k = 0; k < 32; k++) begin
         if (k > 0) begin
            wait_step(d, ok);
            if (!ok) step_lost = 1'b1;
         end else begin
            d = 0;
         end
         case (d)
            0: if (anode == 4'b1110) ok0++;
            1: if (anode == 4'b1101) ok0++;
            2: if (anode == 4'b1111) off1++; else if (anode == 4'b1011) on1++;
            default: begin
               if (anode == 4'b1111) off1++; else if (anode == 4'b0111) on1++;
               if (fr < 8) bl[fr] = (anode == 4'b1111);
               fr++;
            end
         endcase
      end
      if (step_lost) timeout("blink_step");
      for (int f = 0; f < 6; f++) if (bl[f] == bl[f+2]) pat_ok = 1'b0;
      check("blink_p0_shown", ok0, 16);
      check("blink_p1_off", off1, 8);
      check("blink_p1_on", on1, 8);
      check("blink_frames", fr, 8);
      check("blink_two_frame_period", pat_ok, 1'b1);

      // clear priority and clear-all
      wr(1'b0, 4'd1, 8'h03);
      rd(1'b0, 4'd1, 8'h00, "p1_clear_prio");
      check("p1_clear_win", {game_over, win}, 3'b000);
      repeat (3) wr(1'b0, 4'd0, 8'h01);
      repeat (2) wr(1'b0, 4'd1, 8'h01);
      rd(1'b0, 4'd0, 8'h03, "p0_03");
      rd(1'b0, 4'd1, 8'h02, "p1_02");
      wr(1'b0, 4'd15, 8'h01);
      rd(1'b0, 4'd0, 8'h00, "clrall2_p0");
      rd(1'b0, 4'd1, 8'h00, "clrall2_p1");

      // display of 05 / 00
      repeat (5) wr(1'b0, 4'd0, 8'h01);
      check_digit(0, 4'b1110, 8'h92, "disp_d0");
      check_digit(1, 4'b1101, 8'hFF, "disp_d1");
      check_digit(2, 4'b1011, 8'h40, "disp_d2");
      check_digit(3, 4'b0111, 8'hFF, "disp_d3");

      // blank bit
      wr(1'b0, 4'd15, 8'h02);
      rd(1'b0, 4'd15, 8'h04, "ctrl_blank");
      for (int k = 0; k < 8; k++) begin
         wait_step(d, ok);
         if (!ok) timeout("blank_step");
         else check("blank_anode", anode, 4'b1111);
      end
      wr(1'b0, 4'd0, 8'h01);
      rd(1'b0, 4'd0, 8'h06, "blank_p0_06");
      wr(1'b0, 4'd15, 8'h00);
      check_digit(0, 4'b1110, 8'h82, "unblank_d0");

      // unmapped address
      wr(1'b0, 4'd5, 8'h01);
      rd(1'b0, 4'd5, 8'h00, "unmapped_rd");
      rd(1'b0, 4'd0, 8'h06, "unmapped_wr_ignored");
      wr(1'b0, 4'd0, 8'h00);
      check("data_out_hold", data_out, 8'h06);

      // reset wins over a simultaneous increment
      rst = 1'b0;
      wr(1'b0, 4'd0, 8'h01);
      check("rst2_data_out", data_out, 8'h00);
      check("rst2_anode", anode, 4'b1111);
      check("rst2_cathode", cathode, 8'hFF);
      rst = 1'b1;
      rd(1'b0, 4'd0, 8'h00, "rst_prio_p0");
      rd(1'b0, 4'd15, 8'h00, "rst_prio_ctrl");

      repeat (4) @(negedge clk);
      check("rdq_drained", rdq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
